// File: rtl/airlock_controller.sv
// -----------------------------------------------------------------------------
// airlock_controller
//   Sequences a two-door airlock. Issues one-cycle toggle pulses to the outer
//   and inner doors and runs the chamber pump between vented and habitat
//   pressure. It never lets both doors open together and never opens a door
//   while the pump runs. A sticky fault state latches any interlock violation
//   seen on the door sense inputs. Only a reset clears the fault.
//
//   Optional feature macro: AIRLOCK_AUTOCLOSE_EN
//     When defined, an open door closes by itself after AUTOCLOSE_CYCLES
//     cycles without a close request.
//
// Ports
//   i_clock             system clock, all logic on posedge
//   i_reset             synchronous, active-high reset
//   i_reqOuter          request outer door open (1-cycle pulse)
//   i_reqInner          request inner door open (1-cycle pulse)
//   i_reqClose          request the open door to close (1-cycle pulse)
//   i_outerClosed       outer door closed sense
//   i_innerClosed       inner door closed sense
//   o_outerToggle       1-cycle toggle pulse to outer door
//   o_innerToggle       1-cycle toggle pulse to inner door
//   o_pressureChanging  high while the pump runs
//   o_isHighPressure    chamber is at habitat pressure
//   o_busy              high unless idle with both doors closed
//   o_fault             sticky interlock violation flag
//
// States
//   S_LOW_CLOSED   | vented, both doors shut, idle
//   S_OUT_OPENING  | outer toggled, waiting for outer door to report open
//   S_OUT_OPEN     | outer door open
//   S_OUT_CLOSING  | outer toggled, waiting for outer door to report closed
//   S_PRESSURIZE   | pump running toward habitat pressure
//   S_HIGH_CLOSED  | at habitat pressure, both doors shut, idle
//   S_IN_OPENING   | inner toggled, waiting for inner door to report open
//   S_IN_OPEN      | inner door open
//   S_IN_CLOSING   | inner toggled, waiting for inner door to report closed
//   S_DEPRESSURIZE | pump running toward vented pressure
//   S_FAULT        | interlock violated, frozen until reset
// -----------------------------------------------------------------------------
module airlock_controller #(
  parameter int PUMP_CYCLES      = 8,
  parameter int AUTOCLOSE_CYCLES = 16,
  parameter int CNT_W            = 5
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_reqOuter,
  input  logic i_reqInner,
  input  logic i_reqClose,
  input  logic i_outerClosed,
  input  logic i_innerClosed,
  output logic o_outerToggle,
  output logic o_innerToggle,
  output logic o_pressureChanging,
  output logic o_isHighPressure,
  output logic o_busy,
  output logic o_fault
);

  typedef enum logic [3:0] {
    S_LOW_CLOSED,
    S_OUT_OPENING,
    S_OUT_OPEN,
    S_OUT_CLOSING,
    S_PRESSURIZE,
    S_HIGH_CLOSED,
    S_IN_OPENING,
    S_IN_OPEN,
    S_IN_CLOSING,
    S_DEPRESSURIZE,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] LP_PUMP_LOAD = CNT_W'(PUMP_CYCLES - 1);
`ifdef AIRLOCK_AUTOCLOSE_EN
  localparam logic [CNT_W-1:0] LP_AC_LOAD   = CNT_W'(AUTOCLOSE_CYCLES - 1);
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_pending;
  logic             w_pending_next;
  logic             r_high;
  logic             w_high_next;
  logic             r_first;
  logic             w_pumping;
  logic             w_closed_state;
  logic             w_fault_cond;
  logic             w_cnt_zero;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_LOW_CLOSED;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_high    <= 1'b0;
      r_first   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pending <= w_pending_next;
      r_high    <= w_high_next;
      // Marks the first cycle of a state so the door toggle is a single pulse.
      r_first   <= (w_state_next != r_state);
    end
  end

  assign w_pumping      = (r_state == S_PRESSURIZE) || (r_state == S_DEPRESSURIZE);
  assign w_closed_state = (r_state == S_LOW_CLOSED) || (r_state == S_HIGH_CLOSED);
  assign w_cnt_zero     = (r_cnt == '0);
  assign w_fault_cond   = (r_state != S_FAULT) &&
                          ((!i_outerClosed && !i_innerClosed) ||
                           ((w_pumping || w_closed_state) &&
                            (!i_outerClosed || !i_innerClosed)));

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_pending_next = r_pending;
    w_high_next    = r_high;
    if (w_fault_cond) begin
      w_state_next = S_FAULT;
    end else begin
      case (r_state)
        S_LOW_CLOSED: begin
          // A pending request left over from a pump takes precedence.
          if (r_pending) begin
            w_state_next   = S_OUT_OPENING;
            w_pending_next = 1'b0;
          end else if (i_reqOuter) begin
            w_state_next = S_OUT_OPENING;
          end else if (i_reqInner) begin
            w_state_next   = S_PRESSURIZE;
            w_pending_next = 1'b1;
            w_cnt_next     = LP_PUMP_LOAD;
          end
        end
        S_HIGH_CLOSED: begin
          if (r_pending) begin
            w_state_next   = S_IN_OPENING;
            w_pending_next = 1'b0;
          end else if (i_reqInner) begin
            w_state_next = S_IN_OPENING;
          end else if (i_reqOuter) begin
            w_state_next   = S_DEPRESSURIZE;
            w_pending_next = 1'b1;
            w_cnt_next     = LP_PUMP_LOAD;
          end
        end
        S_OUT_OPENING: begin
          if (!i_outerClosed) begin
            w_state_next = S_OUT_OPEN;
`ifdef AIRLOCK_AUTOCLOSE_EN
            w_cnt_next   = LP_AC_LOAD;
`endif
          end
        end
        S_OUT_OPEN: begin
`ifdef AIRLOCK_AUTOCLOSE_EN
          if (i_reqClose || w_cnt_zero) w_state_next = S_OUT_CLOSING;
          else                          w_cnt_next   = r_cnt - CNT_W'(1);
`else
          if (i_reqClose) w_state_next = S_OUT_CLOSING;
`endif
        end
        S_OUT_CLOSING: begin
          if (i_outerClosed) w_state_next = S_LOW_CLOSED;
        end
        S_IN_OPENING: begin
          if (!i_innerClosed) begin
            w_state_next = S_IN_OPEN;
`ifdef AIRLOCK_AUTOCLOSE_EN
            w_cnt_next   = LP_AC_LOAD;
`endif
          end
        end
        S_IN_OPEN: begin
`ifdef AIRLOCK_AUTOCLOSE_EN
          if (i_reqClose || w_cnt_zero) w_state_next = S_IN_CLOSING;
          else                          w_cnt_next   = r_cnt - CNT_W'(1);
`else
          if (i_reqClose) w_state_next = S_IN_CLOSING;
`endif
        end
        S_IN_CLOSING: begin
          if (i_innerClosed) w_state_next = S_HIGH_CLOSED;
        end
        S_PRESSURIZE: begin
          if (w_cnt_zero) begin
            w_state_next = S_HIGH_CLOSED;
            w_high_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        S_DEPRESSURIZE: begin
          if (w_cnt_zero) begin
            w_state_next = S_LOW_CLOSED;
            w_high_next  = 1'b0;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        S_FAULT: w_state_next = S_FAULT;
        default: w_state_next = S_FAULT;
      endcase
    end
  end

  // A toggle is suppressed whenever the other door is not sensed closed or a
  // violation is being detected this cycle; pumping states never toggle.
  always_comb begin
    o_outerToggle      = r_first && !w_fault_cond && i_innerClosed &&
                         ((r_state == S_OUT_OPENING) || (r_state == S_OUT_CLOSING));
    o_innerToggle      = r_first && !w_fault_cond && i_outerClosed &&
                         ((r_state == S_IN_OPENING) || (r_state == S_IN_CLOSING));
    o_pressureChanging = w_pumping;
    o_isHighPressure   = r_high;
    o_busy             = !w_closed_state;
    o_fault            = (r_state == S_FAULT);
  end

endmodule

// File: tb/tb_airlock_controller.sv
module tb_airlock_controller;

  localparam int PUMP = 4;
  localparam int AUTO = 16;

  // Reference model phases; door index 0 = outer, 1 = inner.
  localparam int P_IDLE    = 0;
  localparam int P_OPENING = 1;
  localparam int P_OPEN    = 2;
  localparam int P_CLOSING = 3;
  localparam int P_PUMP    = 4;
  localparam int P_FAULT   = 5;

  typedef struct {
    logic [2:0] req;   // {reqOuter, reqInner, reqClose}
    logic [5:0] exp;   // {outerToggle, innerToggle, pressureChanging, isHighPressure, busy, fault}
  } vec_t;

  logic clk = 1'b0;
  logic rst, r_o, r_i, r_c;
  logic door_oc, door_ic, frc_o, frc_i;
  logic oc, ic;
  logic o_t, i_t, pc, hp, busy, flt;

  int n_checks = 0;
  int n_err    = 0;
  logic [5:0] d_cap;
  logic [5:0] m_exp;

  int m_phase, m_side, m_left, m_ac;
  bit m_hp, m_pend, m_entered;

  vec_t vecs [36];

  always #5 clk = ~clk;

  assign oc = door_oc & ~frc_o;
  assign ic = door_ic & ~frc_i;

  airlock_controller #(
    .PUMP_CYCLES(PUMP),
    .AUTOCLOSE_CYCLES(AUTO),
    .CNT_W(5)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_reqOuter(r_o),
    .i_reqInner(r_i),
    .i_reqClose(r_c),
    .i_outerClosed(oc),
    .i_innerClosed(ic),
    .o_outerToggle(o_t),
    .o_innerToggle(i_t),
    .o_pressureChanging(pc),
    .o_isHighPressure(hp),
    .o_busy(busy),
    .o_fault(flt)
  );

  // Door models: each toggle pulse flips the door one cycle later.
  always @(posedge clk) begin
    if (rst) begin
      door_oc <= 1'b1;
      door_ic <= 1'b1;
    end else begin
      if (o_t) door_oc <= ~door_oc;
      if (i_t) door_ic <= ~door_ic;
    end
  end

  task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock cycle: drive requests, sample DUT and model, advance both.
  task automatic tick(input logic ro, input logic ri, input logic rc);
    bit [1:0] c, req, tog;
    bit fc;
    int n_phase, n_side, n_left, n_ac;
    bit n_hp, n_pend;
    r_o = ro; r_i = ri; r_c = rc;
    #1;
    d_cap = {o_t, i_t, pc, hp, busy, flt};
    c   = {ic, oc};
    req = {ri, ro};
    fc  = (m_phase != P_FAULT) &&
          ((c == 2'b00) || (((m_phase == P_PUMP) || (m_phase == P_IDLE)) && (c != 2'b11)));
    tog = 2'b00;
    if (!fc && m_entered && ((m_phase == P_OPENING) || (m_phase == P_CLOSING)) && c[1 - m_side])
      tog[m_side] = 1'b1;
    m_exp = {tog[0], tog[1], m_phase == P_PUMP, m_hp, m_phase != P_IDLE, m_phase == P_FAULT};

    n_phase = m_phase; n_side = m_side; n_left = m_left; n_ac = m_ac;
    n_hp = m_hp; n_pend = m_pend;
    if (fc) begin
      n_phase = P_FAULT;
    end else begin
      case (m_phase)
        P_IDLE: begin
          // The door on the chamber's current pressure side needs no pump.
          if (m_pend) begin
            n_phase = P_OPENING; n_side = int'(m_hp); n_pend = 1'b0;
          end else if (req[m_hp]) begin
            n_phase = P_OPENING; n_side = int'(m_hp);
          end else if (req[1 - m_hp]) begin
            n_phase = P_PUMP; n_left = PUMP; n_pend = 1'b1;
          end
        end
        P_OPENING: if (!c[m_side]) begin n_phase = P_OPEN; n_ac = 0; end
        P_OPEN: begin
          n_ac = m_ac + 1;
          if (rc) n_phase = P_CLOSING;
`ifdef AIRLOCK_AUTOCLOSE_EN
          if (n_ac == AUTO) n_phase = P_CLOSING;
`endif
        end
        P_CLOSING: if (c[m_side]) n_phase = P_IDLE;
        P_PUMP: begin
          n_left = m_left - 1;
          if (n_left == 0) begin n_phase = P_IDLE; n_hp = ~m_hp; end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    if (rst) begin
      m_phase = P_IDLE; m_side = 0; m_left = 0; m_ac = 0;
      m_hp = 1'b0; m_pend = 1'b0; m_entered = 1'b0;
    end else begin
      m_entered = (n_phase != m_phase);
      m_phase = n_phase; m_side = n_side; m_left = n_left; m_ac = n_ac;
      m_hp = n_hp; m_pend = n_pend;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    bit seen;
    vecs = '{
      '{3'b100, 6'b000000}, '{3'b000, 6'b100010}, '{3'b000, 6'b000010}, '{3'b001, 6'b000010},
      '{3'b000, 6'b100010}, '{3'b000, 6'b000010}, '{3'b010, 6'b000000}, '{3'b000, 6'b001010},
      '{3'b000, 6'b001010}, '{3'b000, 6'b001010}, '{3'b000, 6'b001010}, '{3'b000, 6'b000100},
      '{3'b000, 6'b010110}, '{3'b000, 6'b000110}, '{3'b100, 6'b000110}, '{3'b001, 6'b000110},
      '{3'b000, 6'b010110}, '{3'b000, 6'b000110}, '{3'b100, 6'b000100}, '{3'b000, 6'b001110},
      '{3'b000, 6'b001110}, '{3'b000, 6'b001110}, '{3'b000, 6'b001110}, '{3'b000, 6'b000000},
      '{3'b000, 6'b100010}, '{3'b000, 6'b000010}, '{3'b001, 6'b000010}, '{3'b000, 6'b100010},
      '{3'b000, 6'b000010}, '{3'b110, 6'b000000}, '{3'b000, 6'b100010}, '{3'b000, 6'b000010},
      '{3'b001, 6'b000010}, '{3'b000, 6'b100010}, '{3'b000, 6'b000010}, '{3'b000, 6'b000000}
    };
    rst = 1'b1; r_o = 1'b0; r_i = 1'b0; r_c = 1'b0; frc_o = 1'b0; frc_i = 1'b0;
    m_phase = P_IDLE; m_side = 0; m_left = 0; m_ac = 0;
    m_hp = 1'b0; m_pend = 1'b0; m_entered = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    check6("reset_held", d_cap, 6'b000000);
    tick(1'b0, 1'b0, 1'b0);
    check6("reset_idle", d_cap, 6'b000000);
    n_checks++;
    if ({oc, ic} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_doors: got %b expected 11", {oc, ic});
    end

    // Directed vector table: outer cycle, pressurize+inner, ignored request,
    // depressurize+outer, simultaneous requests.
    for (int i = 0; i < 36; i++) begin
      tick(vecs[i].req[2], vecs[i].req[1], vecs[i].req[0]);
      check6($sformatf("vec%0d", i), d_cap, vecs[i].exp);
    end

    // Outer door forced open mid-pump: fault latches, requests ignored.
    do_reset();
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check6("pump_start", d_cap, 6'b001010);
    frc_o = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check6("fault_entry", d_cap, 6'b000011);
    frc_o = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    check6("fault_req_outer", d_cap, 6'b000011);
    tick(1'b0, 1'b1, 1'b0);
    check6("fault_req_inner", d_cap, 6'b000011);
    tick(1'b0, 1'b0, 1'b1);
    check6("fault_req_close", d_cap, 6'b000011);
    tick(1'b0, 1'b0, 1'b0);
    check6("fault_sticky", d_cap, 6'b000011);
    do_reset();
    tick(1'b0, 1'b0, 1'b0);
    check6("fault_cleared", d_cap, 6'b000000);

    // Fault at habitat pressure keeps isHighPressure.
    tick(1'b0, 1'b1, 1'b0);
    repeat (8) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int j = 0; j < 10 && !seen; j++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (!d_cap[1]) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_err++;
      $display("FAIL wait_high_idle: busy stayed %b expected 0", d_cap[1]);
    end
    check6("high_idle", d_cap, 6'b000100);
    frc_o = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check6("fault_hp_held", d_cap, 6'b000111);
    frc_o = 1'b0;

    // Randomized requests against the reference model.
    do_reset();
    for (int j = 0; j < 3000; j++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      check6("random", d_cap, m_exp);
    end

`ifdef AIRLOCK_AUTOCLOSE_EN
    // Open outer and never request close: toggle AUTO cycles after OPEN entry.
    do_reset();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check6("ac_open_toggle", d_cap, 6'b100010);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 60) begin
      tick(1'b0, 1'b0, 1'b0);
      k++;
      if (d_cap[5]) seen = 1'b1;
    end
    n_checks++;
    if (!seen || k != AUTO + 2) begin
      n_err++;
      $display("FAIL autoclose: toggle after %0d cycles (seen=%0d) expected %0d", k, seen, AUTO + 2);
    end
`else
    k = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
